// File: rtl/avalon_st_pkg.sv
// Shared helpers for Avalon-ST symbol-width adapters: width math, the
// downsizer FSM encoding and the sub-beat planning function used at acceptance.
package avalon_st_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ds_state_t;

    typedef struct packed {
        logic [15:0] valid_syms;
        logic [15:0] last_idx;
        logic [15:0] empty;
    } subbeat_plan_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int p = 1; p < value; p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int empty_w(input int symbols);
        return (clog2(symbols) < 1) ? 1 : clog2(symbols);
    endfunction

    // Sub-beat count (as last index) and final empty for one input beat.
    // An out-of-range empty is clamped so at least one symbol is emitted.
    function automatic subbeat_plan_t plan_subbeats(input int in_syms, input int out_syms,
                                                    input int in_empty, input logic eop);
        subbeat_plan_t plan;
        int            emp;
        int            valid;
        int            beats;
        emp = 0;
        if (eop) begin
            emp = (in_empty >= in_syms) ? in_syms - 1 : in_empty;
        end
        valid           = in_syms - emp;
        beats           = (valid + out_syms - 1) / out_syms;
        plan.valid_syms = 16'(valid);
        plan.last_idx   = 16'(beats - 1);
        plan.empty      = eop ? 16'(beats * out_syms - valid) : 16'd0;
        return plan;
    endfunction

endpackage

// File: rtl/avalon_st_symbol_downsizer.sv
// Avalon-ST symbol downsizer: splits each wide input beat into RATIO narrower
// output sub-beats, MSB slice first, with packet delimiters and empty rewritten.
module avalon_st_symbol_downsizer
    import avalon_st_pkg::*;
#(
    parameter int SYMBOL_W    = 8,
    parameter int IN_SYMBOLS  = 3,
    parameter int OUT_SYMBOLS = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    output logic                                 in_ready,
    input  logic                                 in_valid,
    input  logic [SYMBOL_W*IN_SYMBOLS-1:0]       in_data,
    input  logic                                 in_startofpacket,
    input  logic                                 in_endofpacket,
    input  logic [empty_w(IN_SYMBOLS)-1:0]       in_empty,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic                                 out_startofpacket,
    output logic                                 out_endofpacket,
    output logic [SYMBOL_W*OUT_SYMBOLS-1:0]      out_data,
    output logic [empty_w(OUT_SYMBOLS)-1:0]      out_empty
);

    localparam int IN_W        = SYMBOL_W * IN_SYMBOLS;
    localparam int OUT_W       = SYMBOL_W * OUT_SYMBOLS;
    localparam int REM_W       = IN_W - OUT_W;
    localparam int RATIO       = IN_SYMBOLS / OUT_SYMBOLS;
    localparam int CNT_W       = (clog2(RATIO) < 1) ? 1 : clog2(RATIO);
    localparam int OUT_EMPTY_W = empty_w(OUT_SYMBOLS);

    if ((IN_SYMBOLS % OUT_SYMBOLS) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("IN_SYMBOLS must be a multiple of OUT_SYMBOLS with a ratio of at least 2");
    end

    ds_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [REM_W-1:0]       shift_q, shift_d;
    logic                   eop_pend_q, eop_pend_d;
    logic [OUT_EMPTY_W-1:0] final_empty_q, final_empty_d;
    logic [OUT_W-1:0]       data_q, data_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [OUT_EMPTY_W-1:0] empty_q, empty_d;

    subbeat_plan_t          plan;
    logic [IN_W-1:0]        masked;
    logic                   last_sub;
    logic                   accept;

    assign out_valid         = (state_q == ST_EMIT);
    assign out_data          = data_q;
    assign out_startofpacket = sop_q;
    assign out_endofpacket   = eop_q;
    assign out_empty         = empty_q;

    always_comb begin
        plan     = plan_subbeats(IN_SYMBOLS, OUT_SYMBOLS, int'(in_empty), in_endofpacket);
        last_sub = (cnt_q == '0);
        in_ready = !reset && (!out_valid || (out_ready && last_sub));
        accept   = in_valid && in_ready;

        // Symbols past the packet end are zeroed so padding never leaks out.
        masked = in_data;
        for (int s = 0; s < IN_SYMBOLS; s++) begin
            if (s >= int'(plan.valid_syms)) begin
                masked[(IN_SYMBOLS-1-s)*SYMBOL_W +: SYMBOL_W] = '0;
            end
        end

        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        eop_pend_d    = eop_pend_q;
        final_empty_d = final_empty_q;
        data_d        = data_q;
        sop_d         = sop_q;
        eop_d         = eop_q;
        empty_d       = empty_q;

        if (accept) begin
            state_d       = ST_EMIT;
            cnt_d         = CNT_W'(plan.last_idx);
            data_d        = masked[IN_W-1 -: OUT_W];
            shift_d       = masked[REM_W-1:0];
            eop_pend_d    = in_endofpacket;
            final_empty_d = OUT_EMPTY_W'(plan.empty);
            sop_d         = in_startofpacket;
            eop_d         = in_endofpacket && (plan.last_idx == 16'd0);
            empty_d       = eop_d ? OUT_EMPTY_W'(plan.empty) : '0;
        end else if (state_q == ST_EMIT && out_ready) begin
            if (last_sub) begin
                state_d = ST_IDLE;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
                empty_d = '0;
            end else begin
                cnt_d   = cnt_q - CNT_W'(1);
                data_d  = shift_q[REM_W-1 -: OUT_W];
                shift_d = shift_q << OUT_W;
                sop_d   = 1'b0;
                eop_d   = eop_pend_q && (cnt_q == CNT_W'(1));
                empty_d = eop_d ? final_empty_q : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            eop_pend_q    <= 1'b0;
            final_empty_q <= '0;
            data_q        <= '0;
            sop_q         <= 1'b0;
            eop_q         <= 1'b0;
            empty_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            eop_pend_q    <= eop_pend_d;
            final_empty_q <= final_empty_d;
            data_q        <= data_d;
            sop_q         <= sop_d;
            eop_q         <= eop_d;
            empty_q       <= empty_d;
        end
    end

endmodule

// File: tb/tb_avalon_st_symbol_downsizer.sv
// Bench for avalon_st_symbol_downsizer: a 3:1 default instance and a 4:2 instance,
// each checked every cycle against a per-packet sub-beat queue model.
module tb_avalon_st_symbol_downsizer;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        v0 = 1'b0, sop0 = 1'b0, eop0 = 1'b0, ordy0 = 1'b1;
    logic [23:0] dat0 = '0;
    logic [1:0]  emp0 = '0;
    logic        in_ready0, out_valid0, osop0, oeop0;
    logic [7:0]  odat0;
    logic [0:0]  oemp0;

    logic        v1 = 1'b0, sop1 = 1'b0, eop1 = 1'b0, ordy1 = 1'b1;
    logic [31:0] dat1 = '0;
    logic [1:0]  emp1 = '0;
    logic        in_ready1, out_valid1, osop1, oeop1;
    logic [15:0] odat1;
    logic [0:0]  oemp1;

    int   n_asserts = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   rs[2];
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;

    avalon_st_symbol_downsizer u_dut0 (
        .clk(clk), .reset(reset), .in_ready(in_ready0), .in_valid(v0), .in_data(dat0),
        .in_startofpacket(sop0), .in_endofpacket(eop0), .in_empty(emp0), .out_ready(ordy0),
        .out_valid(out_valid0), .out_startofpacket(osop0), .out_endofpacket(oeop0),
        .out_data(odat0), .out_empty(oemp0)
    );

    avalon_st_symbol_downsizer #(.SYMBOL_W(8), .IN_SYMBOLS(4), .OUT_SYMBOLS(2)) u_dut1 (
        .clk(clk), .reset(reset), .in_ready(in_ready1), .in_valid(v1), .in_data(dat1),
        .in_startofpacket(sop1), .in_endofpacket(eop1), .in_empty(emp1), .out_ready(ordy1),
        .out_valid(out_valid1), .out_startofpacket(osop1), .out_endofpacket(oeop1),
        .out_data(odat1), .out_empty(oemp1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: split a beat into symbols, drop the empty tail, group by nout.
    task automatic gen(input int id, input int nin, input int nout, input logic [31:0] data,
                       input logic sop, input logic eop, input int emp);
        int         nval, nb, idx;
        logic [7:0] sym;
        exp_t       e;
        nval = nin;
        if (eop) nval = nin - ((emp >= nin) ? nin - 1 : emp);
        nb = (nval + nout - 1) / nout;
        for (int k = 0; k < nb; k++) begin
            e.data = '0;
            for (int s = 0; s < nout; s++) begin
                idx = k * nout + s;
                sym = (idx < nval) ? 8'(data >> (8 * (nin - 1 - idx))) : 8'h00;
                e.data = (e.data << 8) | 32'(sym);
            end
            e.sop   = sop && (k == 0);
            e.eop   = eop && (k == nb - 1);
            e.empty = e.eop ? 2'(nb * nout - nval) : 2'd0;
            if (id == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic mon(input int id, input logic rdy, input logic ov, input logic osop,
                       input logic oeop, input logic [31:0] od, input logic [1:0] oe,
                       input logic ordy, input logic iv, input logic [31:0] id_data,
                       input logic isop, input logic ieop, input int iemp,
                       input int nin, input int nout);
        int   sz;
        exp_t f;
        sz = (id == 0) ? q0.size() : q1.size();
        if (reset) begin
            chk($sformatf("d%0d_in_ready_rst", id), 32'(rdy), 32'd0);
            if (rs[id]) begin
                chk($sformatf("d%0d_valid_rst", id), 32'(ov), 32'd0);
                chk($sformatf("d%0d_sop_rst", id), 32'(osop), 32'd0);
                chk($sformatf("d%0d_eop_rst", id), 32'(oeop), 32'd0);
                chk($sformatf("d%0d_data_rst", id), od, 32'd0);
                chk($sformatf("d%0d_empty_rst", id), 32'(oe), 32'd0);
            end
            if (id == 0) q0.delete();
            else q1.delete();
            rs[id] = 1'b1;
            return;
        end
        rs[id] = 1'b0;
        chk($sformatf("d%0d_out_valid", id), 32'(ov), 32'(sz != 0));
        chk($sformatf("d%0d_in_ready", id), 32'(rdy), 32'((sz == 0) || (ordy && sz == 1)));
        if (sz != 0) begin
            f = (id == 0) ? q0[0] : q1[0];
            chk($sformatf("d%0d_data", id), od, f.data);
            chk($sformatf("d%0d_sop", id), 32'(osop), 32'(f.sop));
            chk($sformatf("d%0d_eop", id), 32'(oeop), 32'(f.eop));
            chk($sformatf("d%0d_empty", id), 32'(oe), 32'(f.empty));
            if (ordy) begin
                if (id == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
        if (iv && rdy) gen(id, nin, nout, id_data, isop, ieop, iemp);
    endtask

    always @(negedge clk) begin
        mon(0, in_ready0, out_valid0, osop0, oeop0, {24'd0, odat0}, {1'b0, oemp0}, ordy0,
            v0, {8'd0, dat0}, sop0, eop0, int'(emp0), 3, 1);
        mon(1, in_ready1, out_valid1, osop1, oeop1, {16'd0, odat1}, {1'b0, oemp1}, ordy1,
            v1, dat1, sop1, eop1, int'(emp1), 4, 2);
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            ordy0 = 1'($urandom_range(0, 1));
            ordy1 = 1'($urandom_range(0, 1));
        end
    end

    // Returns one cycle after acceptance, i.e. with the first sub-beat on out_*.
    task automatic send(input int id, input logic [31:0] data, input logic sop,
                        input logic eop, input logic [1:0] emp);
        logic acc;
        int   waited;
        if (id == 0) begin
            v0 = 1'b1; dat0 = data[23:0]; sop0 = sop; eop0 = eop; emp0 = emp;
        end else begin
            v1 = 1'b1; dat1 = data; sop1 = sop; eop1 = eop; emp1 = emp;
        end
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = (id == 0) ? in_ready0 : in_ready1;
            @(posedge clk);
            #1;
            waited++;
        end
        if (id == 0) v0 = 1'b0;
        else v1 = 1'b0;
        chk($sformatf("d%0d_accept_timeout", id), 32'(acc), 32'd1);
    endtask

    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // 0xAABBCC with sop: AA, BB, CC on consecutive cycles
        send(0, 32'hAABBCC, 1'b1, 1'b0, 2'd0);
        chk("req31_aa", 32'(odat0), 32'hAA);
        chk("req31_aa_sop", 32'(osop0), 32'd1);
        @(posedge clk); #1;
        chk("req31_bb", 32'(odat0), 32'hBB);
        chk("req31_bb_sop", 32'(osop0), 32'd0);
        @(posedge clk); #1;
        chk("req31_cc", 32'(odat0), 32'hCC);
        chk("req31_cc_in_ready", 32'(in_ready0), 32'd1);
        @(posedge clk); #1;

        // eop with empty=1: two sub-beats
        send(0, 32'h112233, 1'b0, 1'b1, 2'd1);
        @(posedge clk); #1;
        chk("req32_22", 32'(odat0), 32'h22);
        chk("req32_22_eop", 32'(oeop0), 32'd1);
        @(posedge clk); #1;
        chk("req32_idle", 32'(out_valid0), 32'd0);

        // back-to-back beats, no bubble
        send(0, 32'h010203, 1'b1, 1'b0, 2'd0);
        send(0, 32'h040506, 1'b0, 1'b1, 2'd0);
        chk("req33_second_first", 32'(odat0), 32'h04);
        chk("req33_valid", 32'(out_valid0), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // backpressure on BB
        send(0, 32'hAABBCC, 1'b1, 1'b1, 2'd0);
        @(posedge clk); #1;
        ordy0 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("req34_hold_bb", 32'(odat0), 32'hBB);
            chk("req34_in_ready", 32'(in_ready0), 32'd0);
            @(posedge clk); #1;
        end
        ordy0 = 1'b1;
        @(posedge clk); #1;
        chk("req34_cc", 32'(odat0), 32'hCC);
        @(posedge clk); #1;

        // reset during sub-beat 2 of 3, then an intact packet
        send(0, 32'hAABBCC, 1'b1, 1'b1, 2'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("req36_valid_after_rst", 32'(out_valid0), 32'd0);
        send(0, 32'hDDEEFF, 1'b1, 1'b1, 2'd0);
        chk("req36_dd", 32'(odat0), 32'hDD);
        repeat (3) @(posedge clk);
        #1;

        // 4:2 instance: 0x01020304, eop, empty=1
        send(1, 32'h01020304, 1'b1, 1'b1, 2'd1);
        chk("req35_0102", 32'(odat1), 32'h0102);
        @(posedge clk); #1;
        chk("req35_0300", 32'(odat1), 32'h0300);
        chk("req35_empty", 32'(oemp1), 32'd1);
        chk("req35_eop", 32'(oeop1), 32'd1);
        @(posedge clk); #1;

        // randomized traffic with random backpressure on both instances
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        ordy0 = 1'b1;
        ordy1 = 1'b1;

        waited = 0;
        while ((q0.size() != 0 || q1.size() != 0) && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
